// File: rtl/frame_seq_pkg.sv
// Shared definitions for the frame bit sequencer and the UART wrappers around it.
package frame_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_e;

  localparam int FRAME_CNT_W   = 4;
  localparam int FRAME_MAX_LEN = 11;
  localparam int FRAME_MIN_LEN = 2;

  // Legal-length rule shared by every user of the sequencer
  function automatic logic len_ok(input int unsigned len,
                                  input int unsigned min_len,
                                  input int unsigned max_len);
    return (len >= min_len) && (len <= max_len);
  endfunction

endpackage

// File: rtl/frame_bit_sequencer.sv
// Serial frame bit-position sequencer: steps out through 0..len_r-1, one
// position per en tick, with abort, length error and back-to-back frames.
module frame_bit_sequencer
  import frame_seq_pkg::*;
#(
  parameter int CNT_W   = FRAME_CNT_W,
  parameter int MAX_LEN = FRAME_MAX_LEN,
  parameter int MIN_LEN = FRAME_MIN_LEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic             abort,
  input  logic             cont,
  input  logic [CNT_W-1:0] frame_len,
  output logic [CNT_W-1:0] out,
  output logic             busy,
  output logic             last,
  output logic             done,
  output logic             err
);

  // Parameter sanity: the index must be able to represent every position
  if (2**CNT_W < MAX_LEN) begin : g_bad_cnt_w
    $error("frame_bit_sequencer: 2**CNT_W (%0d) < MAX_LEN (%0d)", 2**CNT_W, MAX_LEN);
  end
  if (MIN_LEN < 2 || MIN_LEN > MAX_LEN) begin : g_bad_min_len
    $error("frame_bit_sequencer: MIN_LEN (%0d) must be in 2..MAX_LEN", MIN_LEN);
  end

  seq_state_e       state, state_nxt;
  logic [CNT_W-1:0] len_r;
  logic [CNT_W-1:0] term_pos;
  logic             term;
  logic             len_legal;

  assign term_pos  = len_r - CNT_W'(1);
  assign term      = (out == term_pos);
  assign len_legal = len_ok(32'(frame_len), MIN_LEN, MAX_LEN);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: abort overrides ticks; en gates every other transition
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else if (en) begin
      case (state)
        IDLE:    if (start && len_legal) state_nxt = RUN;
        RUN:     if (term && !cont)      state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Status outputs derived from state and position
  always_comb begin
    busy = (state == RUN);
    last = (state == RUN) && term;
  end

  // Position counter, latched length and one-cycle status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      out   <= '0;
      len_r <= CNT_W'(MAX_LEN);
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (abort) begin
        out <= '0;
      end else if (en) begin
        case (state)
          IDLE: begin
            if (start) begin
              if (len_legal) begin
                len_r <= frame_len;
                out   <= CNT_W'(1);
              end else begin
                err <= 1'b1;
              end
            end
          end
          RUN: begin
            if (term) begin
              done <= 1'b1;
              // Continuous mode re-enters position 1 with the same length
              out  <= cont ? CNT_W'(1) : '0;
            end else begin
              out <= out + CNT_W'(1);
            end
          end
          default: out <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_bit_sequencer.sv
// Randomized + directed bench for frame_bit_sequencer against a frame-level model.
module tb_frame_bit_sequencer;

  localparam int MAX_A = 11;
  localparam int MIN_A = 2;

  logic       clk = 1'b0;
  logic       rst, en, start, abort, cont;
  logic [3:0] fl;
  logic [4:0] fl_b;
  logic [3:0] out;
  logic       busy, last, done, err;
  logic [4:0] out_b;
  logic       busy_b, last_b, done_b, err_b;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: a frame is "running" at some position of some length
  int m_pos, m_len;
  bit m_run, m_done, m_err;

  always #5 clk = ~clk;

  frame_bit_sequencer dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .abort(abort), .cont(cont),
    .frame_len(fl), .out(out), .busy(busy), .last(last), .done(done), .err(err)
  );

  frame_bit_sequencer #(.CNT_W(5), .MAX_LEN(20), .MIN_LEN(2)) dut_b (
    .clk(clk), .rst(rst), .en(en), .start(start), .abort(abort), .cont(cont),
    .frame_len(fl_b), .out(out_b), .busy(busy_b), .last(last_b), .done(done_b), .err(err_b)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Advance the model by one clock using the currently driven inputs
  task automatic model_step();
    m_done = 0;
    m_err  = 0;
    if (rst) begin
      m_pos = 0; m_run = 0; m_len = MAX_A;
    end else if (abort) begin
      m_pos = 0; m_run = 0;
    end else if (en) begin
      if (!m_run) begin
        if (start) begin
          if (int'(fl) >= MIN_A && int'(fl) <= MAX_A) begin
            m_len = int'(fl); m_run = 1; m_pos = 1;
          end else begin
            m_err = 1;
          end
        end
      end else if (m_pos == m_len - 1) begin
        m_done = 1;
        if (cont) m_pos = 1;
        else begin m_pos = 0; m_run = 0; end
      end else begin
        m_pos = m_pos + 1;
      end
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check("out",  int'(out),  m_pos);
    check("busy", int'(busy), int'(m_run));
    check("last", int'(last), int'(m_run && (m_pos == m_len - 1)));
    check("done", int'(done), int'(m_done));
    check("err",  int'(err),  int'(m_err));
  endtask

  task automatic drive(input bit r, input bit e, input bit s, input bit a,
                       input bit c, input int len);
    rst = r; en = e; start = s; abort = a; cont = c; fl = 4'(len);
  endtask

  initial begin
    m_pos = 0; m_len = MAX_A; m_run = 0;
    fl_b = '0;
    drive(1, 0, 0, 0, 0, 0);
    cyc();
    cyc();

    // Legacy-equivalent 11-position frame
    drive(0, 1, 1, 0, 0, 11); cyc();
    start = 0;
    for (int i = 0; i < 12; i++) cyc();

    // Half-rate ticks; restart attempt and length change while busy
    for (int i = 0; i < 14; i++) begin
      drive(0, i[0] == 1'b0, (i == 0) || (i == 4), 0, 0, (i >= 3) ? 9 : 4);
      cyc();
    end

    // Continuous 3-position frames, then drop cont
    drive(0, 1, 1, 0, 1, 3); cyc();
    start = 0;
    for (int i = 0; i < 9; i++) cyc();
    cont = 0;
    for (int i = 0; i < 4; i++) cyc();

    // Illegal lengths, then the shortest legal one
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 1, 0, 0, (k == 0) ? 0 : (k == 1) ? 1 : 12); cyc();
      start = 0; cyc();
    end
    drive(0, 1, 1, 0, 0, 2); cyc();
    start = 0; cyc(); cyc();

    // Abort at position 5 with no tick
    drive(0, 1, 1, 0, 0, 11); cyc();
    start = 0;
    for (int i = 0; i < 4; i++) cyc();
    drive(0, 0, 0, 1, 0, 11); cyc();
    abort = 0; cyc();

    // Reset at position 7 together with a tick
    drive(0, 1, 1, 0, 0, 11); cyc();
    start = 0;
    for (int i = 0; i < 6; i++) cyc();
    drive(1, 1, 0, 0, 0, 11); cyc();
    rst = 0; cyc();

    // Wide variant: 20-position frame on the CNT_W=5 instance
    drive(1, 0, 0, 0, 0, 0); cyc();
    drive(0, 1, 1, 0, 0, 0); fl_b = 5'd20; cyc();
    check("b_out", int'(out_b), 1);
    start = 0;
    for (int i = 2; i <= 19; i++) begin
      cyc();
      check("b_out", int'(out_b), i);
      check("b_last", int'(last_b), int'(i == 19));
    end
    cyc();
    check("b_out_end", int'(out_b), 0);
    check("b_done", int'(done_b), 1);
    check("b_busy", int'(busy_b), 0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      drive($urandom_range(0, 199) == 0,
            $urandom_range(0, 9) < 7,
            $urandom_range(0, 9) < 3,
            $urandom_range(0, 39) == 0,
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 15));
      fl_b = 5'($urandom_range(0, 31));
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
